// File: rtl/bash_pkg.sv
// Shared definitions for the SSshell command responder.
// Holds the FSM state enum, command / message ids, line-length limits
// and the ASCII patterns of the recognised commands.
package bash_pkg;

  localparam int unsigned MAX_LEN       = 32;  // command buffer depth in characters
  localparam int unsigned BASH_HEAD_LEN = 9;   // prompt head length, shared with the terminal
  localparam int unsigned LEN_W         = 6;   // width of line length / indices
  localparam int unsigned MSG_OFF_W     = 5;   // character offset inside a ROM message
  localparam int unsigned ECHO_SKIP     = 5;   // characters of "echo " dropped from the reply

  localparam logic [7:0]  ASCII_SPACE   = 8'h20;
  localparam logic [31:0] CMD_ECHO_STR  = "echo";
  localparam logic [39:0] CMD_HELLO_STR = "hello";

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_DECODE,
    ST_SEND,
    ST_SOLVE
  } state_t;

  typedef enum logic [1:0] {
    CMD_EMPTY,
    CMD_HELLO,
    CMD_ECHO,
    CMD_UNKNOWN
  } cmd_t;

  typedef enum logic [0:0] {
    MSG_HELLO,
    MSG_UNKNOWN
  } msg_id_t;

endpackage

// File: rtl/bash_msg_rom.sv
// Fixed response strings, combinational lookup by {message id, offset}.
// Contents mirror init_files/bash_msgs.txt; each message is left-aligned
// in a 32-character slot and padded with NUL, so a message ends at its
// first 0 byte.
// Ports: msg_id_i - message select, off_i - character offset,
//        char_o   - character at that offset (0 past the end).
module bash_msg_rom
  import bash_pkg::*;
(
  input  msg_id_t              msg_id_i,
  input  logic [MSG_OFF_W-1:0] off_i,
  output logic [7:0]           char_o
);

  localparam logic [255:0] MSG_TBL [2] = '{
    {"Hello World!",      160'h0},
    {"command not found", 120'h0}
  };

  // Offset 0 is the most significant byte: bit base = (31 - off) * 8.
  logic [7:0] bit_lo;
  assign bit_lo = {~off_i, 3'b000};
  assign char_o = MSG_TBL[msg_id_i][bit_lo +: 8];

endmodule

// File: rtl/bash_cmd_server.sv
// Command responder for the SSshell terminal.
// Reads a command line from the terminal line-output port, classifies it
// (empty / hello / echo / unknown), streams the NUL-terminated reply into
// the terminal line-input port and finishes with a solved/ack handshake.
// Ports: line_ready/line_len/line_char/line_next - command read side,
//        resp_ready/resp_char/resp_next          - response write side,
//        solved/solved_ack                       - completion handshake,
//        busy                                    - high outside IDLE.
module bash_cmd_server
  import bash_pkg::*;
#(
  parameter int unsigned MAX_LEN = bash_pkg::MAX_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line_ready,
  input  logic [LEN_W-1:0] line_len,
  input  logic [7:0]       line_char,
  output logic             line_next,
  output logic             resp_ready,
  output logic [7:0]       resp_char,
  input  logic             resp_next,
  output logic             solved,
  input  logic             solved_ack,
  output logic             busy
);

  localparam int unsigned BIDX_W = $clog2(MAX_LEN);

  state_t           state_q;
  cmd_t             cmd_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] ptr_q;
  logic             line_next_q;
  logic             resp_ready_q;
  logic [7:0]       resp_char_q;
  logic             solved_q;
  logic             busy_q;
  logic [7:0]       buf_q [MAX_LEN];

  cmd_t             cmd_c;
  cmd_t             cmd_sel_c;
  msg_id_t          msg_c;
  logic [39:0]      head5_c;
  logic [LEN_W-1:0] off_c;
  logic [LEN_W-1:0] pos_c;
  logic [LEN_W-1:0] rx_end_c;
  logic [7:0]       rom_char_c;
  logic [7:0]       next_char_c;

  // Gated with line_ready so a consume pulse never appears once the
  // terminal has withdrawn the line.
  assign line_next  = line_next_q & line_ready;
  assign resp_ready = resp_ready_q;
  assign resp_char  = resp_char_q;
  assign solved     = solved_q;
  assign busy       = busy_q;

  // Command buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_RECV && line_next_q && line_ready && idx_q < LEN_W'(MAX_LEN))
      buf_q[idx_q[BIDX_W-1:0]] <= line_char;
  end

  // Classify the received line; idx_q holds the number of characters taken.
  assign head5_c = {buf_q[0], buf_q[1], buf_q[2], buf_q[3], buf_q[4]};

  always_comb begin
    cmd_c = CMD_UNKNOWN;
    if (idx_q == '0)
      cmd_c = CMD_EMPTY;
    else if (idx_q == LEN_W'(5) && head5_c == CMD_HELLO_STR)
      cmd_c = CMD_HELLO;
    else if ((idx_q == LEN_W'(4) && head5_c[39:8] == CMD_ECHO_STR) ||
             (idx_q > LEN_W'(4) && head5_c == {CMD_ECHO_STR, ASCII_SPACE}))
      cmd_c = CMD_ECHO;
  end

  // Character to present next: offset 0 while decoding, ptr+1 while sending.
  always_comb begin
    cmd_sel_c   = (state_q == ST_DECODE) ? cmd_c : cmd_q;
    off_c       = (state_q == ST_DECODE) ? '0 : ptr_q + LEN_W'(1);
    rx_end_c    = (idx_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : idx_q;
    pos_c       = off_c + LEN_W'(ECHO_SKIP);
    msg_c       = (cmd_sel_c == CMD_HELLO) ? MSG_HELLO : MSG_UNKNOWN;
    next_char_c = rom_char_c;
    if (cmd_sel_c == CMD_ECHO)
      next_char_c = (pos_c < rx_end_c) ? buf_q[pos_c[BIDX_W-1:0]] : 8'h00;
  end

  bash_msg_rom u_rom (
    .msg_id_i (msg_c),
    .off_i    (off_c[MSG_OFF_W-1:0]),
    .char_o   (rom_char_c)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= CMD_EMPTY;
      len_q        <= '0;
      idx_q        <= '0;
      ptr_q        <= '0;
      line_next_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      resp_char_q  <= 8'h00;
      solved_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (line_ready) begin
            len_q  <= line_len;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (line_len == '0) begin
              state_q <= ST_DECODE;
            end else begin
              state_q     <= ST_RECV;
              line_next_q <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (line_next_q) begin
            // Sample cycle: the character is written by the buffer process.
            line_next_q <= 1'b0;
            if (line_ready) idx_q <= idx_q + LEN_W'(1);
            else            state_q <= ST_DECODE;
          end else if (!line_ready || idx_q == len_q) begin
            state_q <= ST_DECODE;
          end else begin
            line_next_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          cmd_q <= cmd_c;
          ptr_q <= '0;
          if (cmd_c == CMD_EMPTY) begin
            state_q  <= ST_SOLVE;
            solved_q <= 1'b1;
          end else begin
            state_q      <= ST_SEND;
            resp_ready_q <= 1'b1;
            resp_char_q  <= next_char_c;
          end
        end
        ST_SEND: begin
          if (resp_next) begin
            if (resp_char_q == 8'h00) begin
              resp_ready_q <= 1'b0;
              state_q      <= ST_SOLVE;
              solved_q     <= 1'b1;
            end else begin
              ptr_q       <= ptr_q + LEN_W'(1);
              resp_char_q <= next_char_c;
            end
          end
        end
        ST_SOLVE: begin
          if (solved_ack) begin
            solved_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bash_cmd_server.sv
// Scoreboard bench for bash_cmd_server: a terminal model issues directed
// command lines, pushing the expected line_next cycles and reply bytes into
// queues; a monitor pops and compares on every DUT handshake.
module tb_bash_cmd_server;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_ready;
  logic [5:0] line_len;
  logic [7:0] line_char;
  logic       line_next;
  logic       resp_ready;
  logic [7:0] resp_char;
  logic       resp_next;
  logic       solved;
  logic       solved_ack;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q [$];
  int         np_q  [$];
  logic       hold_prev = 1'b0;
  logic [7:0] prev_char = 8'h00;

  bash_cmd_server #(.MAX_LEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_ready (line_ready),
    .line_len   (line_len),
    .line_char  (line_char),
    .line_next  (line_next),
    .resp_ready (resp_ready),
    .resp_char  (resp_char),
    .resp_next  (resp_next),
    .solved     (solved),
    .solved_ack (solved_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d (0x%0h) at cycle %0d", name, act, act, cyc);
  endtask

  // Monitor: compares DUT handshakes against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (line_next) begin
        if (np_q.size() == 0) fail("line_next unexpected", cyc);
        else                  check("line_next cycle", cyc, np_q.pop_front());
      end
      if (resp_ready && resp_next) begin
        if (exp_q.size() == 0) fail("resp_char unexpected", int'(resp_char));
        else                   check("resp_char", int'(resp_char), int'(exp_q.pop_front()));
      end else if (resp_ready && hold_prev) begin
        check("resp_char stable", int'(resp_char), int'(prev_char));
      end
      hold_prev <= resp_ready && !resp_next;
      prev_char <= resp_char;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  // Terminal model for one command. ack_delay < 0: solved_ack held high
  // before solved rises. abort: reset as soon as the reply starts.
  task automatic run_cmd(input string s, input string rsp, input int stall_at,
                         input int stall_len, input int ack_delay, input bit abort);
    int n, rd, guard, sent, c0, lowcnt;
    logic nx, rr, sv;
    n = s.len();
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < n; k++) np_q.push_back(c0 + 1 + 2 * k);
    if (n > 0) begin
      for (int k = 0; k < rsp.len(); k++) exp_q.push_back(rsp[k]);
      exp_q.push_back(8'h00);
    end
    if (ack_delay < 0) solved_ack = 1'b1;
    line_ready = 1'b1;
    line_len   = 6'(n);
    line_char  = (n > 0) ? s[0] : 8'h00;
    rd = 0;
    guard = 0;
    do begin
      @(negedge clk); nx = line_next;
      @(posedge clk); #1;
      guard++;
      if (nx) begin
        rd++;
        line_char = (rd < n) ? s[rd] : 8'h00;
      end
    end while (rd < n && guard < 200);
    if (rd < n) fail("line receive timeout", rd);
    line_ready = 1'b0;

    sent = 0;
    guard = 0;
    sv = 1'b0;
    while (guard < 20000) begin
      @(negedge clk); rr = resp_ready; sv = solved;
      if (sv || (abort && rr)) break;
      @(posedge clk); #1;
      guard++;
      if (resp_next) resp_next = 1'b0;
      else if (rr) begin
        if (sent == stall_at) begin
          repeat (stall_len) @(posedge clk);
          #1;
        end
        resp_next = 1'b1;
        sent++;
      end
    end

    if (abort) begin
      if (!rr) fail("reply never started", sent);
      #2 rst = 1'b1;
      #1;
      check("rst line_next",  int'(line_next),  0);
      check("rst resp_ready", int'(resp_ready), 0);
      check("rst resp_char",  int'(resp_char),  0);
      check("rst solved",     int'(solved),     0);
      check("rst busy",       int'(busy),       0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    if (!sv) fail("solved timeout", guard);
    if (n == 0) check("empty solved cycle", cyc, c0 + 2);
    check("resp chars missing", exp_q.size(), 0);
    check("line_next missing", np_q.size(), 0);

    if (ack_delay < 0) begin
      @(negedge clk);
      check("early ack solved", int'(solved), 0);
      check("early ack busy",   int'(busy),   0);
      @(posedge clk); #1 solved_ack = 1'b0;
    end else begin
      lowcnt = 0;
      repeat (ack_delay) begin
        @(negedge clk);
        if (!solved) lowcnt++;
      end
      check("solved held", lowcnt, 0);
      @(posedge clk); #1 solved_ack = 1'b1;
      @(posedge clk); #1 solved_ack = 1'b0;
      @(negedge clk);
      check("ack solved", int'(solved), 0);
      check("ack busy",   int'(busy),   0);
    end
  endtask

  localparam int NV = 12;
  string cmd_v [NV] = '{"hello", "echo abc", "echo", "foo", "", "echo ",
                        "hello!", "Hello", "echo 0123456789abcdefghijklmnopqrstu",
                        "hello", "hello", "echo x"};
  string rsp_v [NV] = '{"Hello World!", "abc", "", "command not found", "", "",
                        "command not found", "command not found",
                        "0123456789abcdefghijklmnopq",
                        "Hello World!", "Hello World!", "x"};
  int stall_v [NV] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 5, -1, -1};
  int ack_v   [NV] = '{3, 0, 1, 2, -1, 0, 0, 0, 1, 4000, 0, 2};
  bit abort_v [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    rst = 1'b1;
    line_ready = 1'b0;
    line_len   = '0;
    line_char  = '0;
    resp_next  = 1'b0;
    solved_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset line_next",  int'(line_next),  0);
    check("reset resp_ready", int'(resp_ready), 0);
    check("reset resp_char",  int'(resp_char),  0);
    check("reset solved",     int'(solved),     0);
    check("reset busy",       int'(busy),       0);
    @(posedge clk); #1 rst = 1'b0;

    for (int v = 0; v < NV; v++)
      run_cmd(cmd_v[v], rsp_v[v], stall_v[v], 4000, ack_v[v], abort_v[v]);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
